// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

  localparam logic [7:0] PS2_PFX_EXT    = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK    = 8'hF0;
  localparam int         PS2_FRAME_BITS = 11;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame deserialiser: pin synchronisers, falling-edge strobe, 11-bit frame
// counter, start/parity/stop check. With PS2_RX_TIMEOUT_EN defined, a watchdog
// aborts a frame whose ps2_clk stalls for TIMEOUT_CYC clk cycles.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_byte_vld,
  output logic [7:0] o_byte,
  output logic       o_frame_err
);

  localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_BITS - 1);

  logic       r_clk_s1, r_clk_s2, r_clk_hist;
  logic       r_dat_s1, r_dat_s2;
  logic [3:0] r_cnt;
  logic [9:0] r_buf;
  logic       w_strobe, w_last, w_ok, w_timeout;

  // Two-FF synchronisers on both pins plus a history FF for edge detection.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_hist <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= i_ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_hist <= r_clk_s2;
      r_dat_s1   <= i_ps2_data;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_strobe = r_clk_hist & ~r_clk_s2;
  assign w_last   = w_strobe & (r_cnt == LAST_BIT);
  // Start bit low, odd parity across data+parity, stop bit (live on the pin) high.
  assign w_ok     = ~r_buf[0] & (^r_buf[9:1]) & r_dat_s2;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] r_wd;

  assign w_timeout = (r_cnt != 4'd0) & ~w_strobe & (r_wd == WD_W'(TIMEOUT_CYC - 1));

  // Watchdog: counts idle cycles inside a frame, reloads on every strobe.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)                            r_wd <= '0;
    else if (w_strobe || r_cnt == 4'd0)   r_wd <= '0;
    else if (w_timeout)                   r_wd <= '0;
    else                                  r_wd <= r_wd + WD_W'(1);
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Bit counter: 0..10, one step per strobe, back to 0 at end of frame or on abort.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)                   r_cnt <= 4'd0;
    else if (w_timeout)          r_cnt <= 4'd0;
    else if (w_strobe) begin
      if (r_cnt == LAST_BIT)     r_cnt <= 4'd0;
      else                       r_cnt <= r_cnt + 4'd1;
    end
  end

  // Shift register for start, data and parity bits (LSB first on the wire).
  always_ff @(posedge clk) begin
    if (w_strobe && r_cnt != LAST_BIT) r_buf <= {r_dat_s2, r_buf[9:1]};
  end

  assign o_byte_vld  = w_last & w_ok;
  assign o_byte      = r_buf[8:1];
  assign o_frame_err = (w_last & ~w_ok) | w_timeout;

endmodule

// File: rtl/ps2_rx_event.sv
// PS/2 receiver top: folds E0/F0 prefix bytes into per-event flags and queues
// events in a show-ahead FIFO with level and sticky overflow reporting.
// Optional macro PS2_RX_TIMEOUT_EN enables the mid-frame watchdog in ps2_frame_rx.
module ps2_rx_event
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                        clk,
  input  logic                        clrn,
  input  logic                        ps2_clk,
  input  logic                        ps2_data,
  output logic                        evt_valid,
  input  logic                        evt_rd,
  output logic [7:0]                  evt_code,
  output logic                        evt_ext,
  output logic                        evt_brk,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow,
  input  logic                        ovf_clr,
  output logic                        frame_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic             w_byte_vld, w_frame_err;
  logic [7:0]       w_byte;
  logic             r_ext, r_brk;
  logic             r_frame_err;
  logic             r_overflow;
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  ps2_evt_t         r_mem [FIFO_DEPTH];
  ps2_evt_t         w_evt_in, w_head;
  logic             w_is_pfx, w_push, w_pop, w_full, w_wr_en;

  ps2_frame_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_frame (
    .clk        (clk),
    .clrn       (clrn),
    .i_ps2_clk  (ps2_clk),
    .i_ps2_data (ps2_data),
    .o_byte_vld (w_byte_vld),
    .o_byte     (w_byte),
    .o_frame_err(w_frame_err)
  );

  assign w_is_pfx = (w_byte == PS2_PFX_EXT) | (w_byte == PS2_PFX_BRK);
  assign w_push   = w_byte_vld & ~w_is_pfx;
  assign w_pop    = evt_rd & (r_level != '0);
  assign w_full   = (r_level == LVL_W'(FIFO_DEPTH));
  // When full, a same-cycle pop frees the slot the push needs.
  assign w_wr_en  = w_push & (~w_full | w_pop);
  assign w_evt_in = '{ext: r_ext, brk: r_brk, code: w_byte};

  // Prefix flags: set by E0/F0, consumed by the next real code, dropped on a bad frame.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (w_frame_err) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (w_byte_vld) begin
      if (w_byte == PS2_PFX_EXT)      r_ext <= 1'b1;
      else if (w_byte == PS2_PFX_BRK) r_brk <= 1'b1;
      else begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
    end
  end

  // FIFO storage; only written, never reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_evt_in;
  end

  // FIFO pointers, occupancy, sticky overflow and the registered error pulse.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_frame_err;
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_level <= r_level + LVL_W'(w_wr_en) - LVL_W'(w_pop);
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      else if (ovf_clr)               r_overflow <= 1'b0;
    end
  end

  assign w_head    = r_mem[r_rd_ptr];
  assign evt_valid = (r_level != '0);
  assign evt_code  = evt_valid ? w_head.code : 8'h00;
  assign evt_ext   = evt_valid & w_head.ext;
  assign evt_brk   = evt_valid & w_head.brk;
  assign level     = r_level;
  assign overflow  = r_overflow;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_rx_event.sv
// Self-checking bench for ps2_rx_event: directed scenarios plus randomized
// frames against a queue-based reference model.
module tb_ps2_rx_event;

  localparam int DEPTH = 8;
  localparam int TO    = 200;
  localparam int HALF  = 10;

  logic       clk = 1'b0, clrn = 1'b0;
  logic       ps2_clk = 1'b1, ps2_data = 1'b1;
  logic       evt_rd = 1'b0, ovf_clr = 1'b0;
  logic       evt_valid, evt_ext, evt_brk, overflow, frame_err;
  logic [7:0] evt_code;
  logic [$clog2(DEPTH):0] level;

  int n_tests = 0, n_fail = 0, err_seen = 0;

  logic [9:0] m_q[$];
  bit         m_ext = 0, m_brk = 0, m_ovf = 0;
  int         m_err = 0;

  ps2_rx_event #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .evt_valid(evt_valid), .evt_rd(evt_rd), .evt_code(evt_code),
    .evt_ext(evt_ext), .evt_brk(evt_brk), .level(level),
    .overflow(overflow), .ovf_clr(ovf_clr), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err === 1'b1) err_seen++;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: one frame's effect on the event queue.
  task automatic model_frame(input logic [7:0] b, input int bad, input bit pop);
    if (pop && m_q.size() > 0) void'(m_q.pop_front());
    if (bad != 0) begin
      m_ext = 0; m_brk = 0; m_err++;
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (m_q.size() < DEPTH) m_q.push_back({m_ext, m_brk, b});
      else m_ovf = 1;
      m_ext = 0; m_brk = 0;
    end
  endtask

  // bad: 0 good, 1 parity flipped, 2 stop low, 3 start high.
  task automatic send_frame(input logic [7:0] b, input int bad, input int nbits,
                            input bit pop, input bit lat);
    logic [10:0] bits;
    bits = {(bad != 2), (~^b) ^ (bad == 1), b, (bad == 3)};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) begin
        repeat (2) @(negedge clk);
        if (lat) chk("lat.before", evt_valid, 1'b0);
        evt_rd = pop;
        @(negedge clk);
        evt_rd = 1'b0;
        if (lat) chk("lat.after", evt_valid, 1'b1);
        repeat (HALF - 3) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] b, input int bad, input bit pop);
    send_frame(b, bad, 11, pop, 1'b0);
    model_frame(b, bad, pop);
  endtask

  task automatic check_state(input string tag);
    logic [9:0] h;
    h = (m_q.size() > 0) ? m_q[0] : 10'h0;
    chk({tag, ".valid"}, evt_valid, (m_q.size() > 0));
    chk({tag, ".level"}, level, m_q.size());
    chk({tag, ".head"}, {evt_ext, evt_brk, evt_code}, h);
    chk({tag, ".ovf"}, overflow, m_ovf);
    chk({tag, ".ferr"}, err_seen, m_err);
  endtask

  task automatic pop_one();
    evt_rd = 1'b1;
    @(negedge clk);
    evt_rd = 1'b0;
    if (m_q.size() > 0) void'(m_q.pop_front());
  endtask

  task automatic clear_ovf();
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    m_ovf = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_state("reset");
    chk("reset.ferr_pin", frame_err, 1'b0);
    clrn = 1'b1;
    repeat (3) @(negedge clk);

    // 1: single plain code, with push latency check
    send_frame(8'h1C, 0, 11, 1'b0, 1'b1);
    model_frame(8'h1C, 0, 1'b0);
    check_state("t1");
    pop_one();
    check_state("t1.pop");

    // 2: prefix folding
    frame(8'hF0, 0, 0); frame(8'h1C, 0, 0);
    frame(8'hE0, 0, 0); frame(8'hF0, 0, 0); frame(8'h75, 0, 0);
    check_state("t2");
    pop_one(); check_state("t2.pop1");
    pop_one(); check_state("t2.pop2");

    // 3: rejected frames, and a prefix cleared by a rejected frame
    frame(8'h1C, 1, 0); check_state("t3.par");
    frame(8'h32, 0, 0); check_state("t3.good");
    frame(8'hE0, 0, 0); frame(8'h44, 2, 0); check_state("t3.stop");
    frame(8'h55, 3, 0); check_state("t3.start");
    frame(8'h66, 0, 0); check_state("t3.after");
    pop_one(); pop_one(); check_state("t3.drain");

    // 4: overflow, full push+pop, ovf_clr, drain
    for (int i = 0; i <= DEPTH; i++) frame(8'h10 + 8'(i), 0, 0);
    check_state("t4.full");
    frame(8'h40, 0, 1);
    check_state("t4.pushpop");
    clear_ovf();
    check_state("t4.clr");
    for (int i = 0; i < DEPTH; i++) begin
      pop_one();
      check_state("t4.drain");
    end
    pop_one();
    check_state("t4.empty_rd");

`ifdef PS2_RX_TIMEOUT_EN
    // 5: watchdog aborts a truncated frame and clears the pending prefix
    frame(8'hE0, 0, 0);
    send_frame(8'h00, 0, 4, 1'b0, 1'b0);
    repeat (TO + 5) @(negedge clk);
    m_ext = 0; m_brk = 0; m_err++;
    check_state("t5.abort");
    frame(8'h1C, 0, 0);
    check_state("t5.next");
    pop_one();
`endif

    // randomized frames, pops and overflow clears
    for (int it = 0; it < 40; it++) begin
      logic [7:0] b;
      int bad;
      bit pop;
      if ($urandom_range(0, 3) == 0) b = ($urandom_range(0, 1) == 1) ? 8'hE0 : 8'hF0;
      else b = 8'($urandom);
      bad = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
      pop = ($urandom_range(0, 3) == 0);
      frame(b, bad, pop);
      check_state("rnd.frame");
      if ($urandom_range(0, 2) == 0) begin
        pop_one();
        check_state("rnd.pop");
      end
      if (m_ovf && $urandom_range(0, 1) == 1) begin
        clear_ovf();
        check_state("rnd.clr");
      end
    end

    // 6: async reset mid-frame with three queued events
    while (m_q.size() > 0) pop_one();
    if (m_ovf) clear_ovf();
    m_ext = 0; m_brk = 0;
    frame(8'h00, 1, 0);
    frame(8'h21, 0, 0); frame(8'h22, 0, 0); frame(8'h23, 0, 0);
    check_state("t6.pre");
    send_frame(8'h5A, 0, 4, 1'b0, 1'b0);
    clrn = 1'b0;
    #1;
    m_q.delete(); m_ext = 0; m_brk = 0; m_ovf = 0;
    chk("t6.rst.valid", evt_valid, 1'b0);
    chk("t6.rst.level", level, 0);
    chk("t6.rst.head", {evt_ext, evt_brk, evt_code}, 10'h0);
    chk("t6.rst.ovf", overflow, 1'b0);
    chk("t6.rst.ferr", frame_err, 1'b0);
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    repeat (3) @(negedge clk);
    frame(8'h29, 0, 0);
    check_state("t6.after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
